audio_burst_reader: RTL
=======================

Name: audio_burst_reader

Overview:
- Parametrised successor of the per-line audio FIFO reader in the HDMI output path.
- Sits between the dual-clock audio sample FIFO (read side, pixel clock domain) and the HDMI data-island packetiser.
- Keeps its own raster position counters and issues one bounded read burst per video line at a fixed horizontal slot.
- Tags each sample with a channel index and counts underruns.

Parameters:
- DATA_W, 32, sample word width from the FIFO.
- H_TOTAL, 858, clocks per line.
- V_TOTAL, 525, lines per frame.
- BURST_START, 0, h position that opens the read window.
- BURST_LEN, 4, maximum samples read per line, 1..15.
- CHANNELS, 2, channels interleaved in the FIFO stream, 1..8.
- Legality: BURST_START+BURST_LEN+2 < H_TOTAL.

Ports:
- rclock  in  1  pixel/read clock.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  DATA_W  FIFO q, valid the cycle after an accepted rdreq.
- rdempty  in  1  FIFO empty.
- rdreq  out  1  FIFO read request.
- out_data  out  DATA_W  captured sample.
- out_valid  out  1  out_data/out_ch valid this cycle.
- out_ch  out  3  channel index of out_data.
- frame_start  out  1  one-cycle pulse at h=0,v=0.
- underrun_cnt  out  16  saturating count of short bursts.
- test_tone  in  1  only present with AUDIO_TEST_TONE_EN.

Behaviour:
Reset (reset_n low, asynchronous):
- h_cnt=0, v_cnt=0, state=IDLE, issued=0.
- out_data=0, out_valid=0, out_ch=0, frame_start=0, underrun_cnt=0, rdreq=0.

Raster counters:
- h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
- On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- frame_start is registered. It is high in the cycle where h_cnt=0 and v_cnt=0.

FSM:
- IDLE: when h_cnt==BURST_START, go to READ next cycle with issued=0.
- READ:
  - rdreq = !rdempty && issued<BURST_LEN. This is combinational, so rdreq is never high while rdempty=1.
  - Each accepted rdreq increments issued.
  - When issued reaches BURST_LEN, go to DRAIN.
  - When rdempty=1 and issued<BURST_LEN, go to DRAIN and flag a short burst.
  - The short-burst flag is also set when issued=0 (no sample available at all on that line).
- DRAIN: one cycle, then return to IDLE. Underrun_cnt increments here if the burst was flagged short. It saturates at 0xFFFF.

Output pipeline:
- An rdreq accepted in cycle N gives out_valid=1 in cycle N+2, with out_data = the FIFO word from cycle N+1.
- out_valid is 0 in all other cycles. out_data holds its last value when out_valid=0.
- out_ch is the channel of the word currently on out_data. It starts at 0 after reset.
- The channel counter advances after every valid sample and wraps CHANNELS-1 -> 0.
- The channel index carries across bursts and lines. A stereo pair may be split across lines.
- out_ch is not reset at frame start.

Boundary conditions:
- rdempty deasserting mid-window after a short burst does not restart READ. The next read waits for the next line's BURST_START.
- Reset mid-burst aborts the burst immediately. Any outstanding FIFO word is discarded; out_valid is 0 after reset.
- A burst opening on the frame-wrap line is unaffected by frame_start. Both can occur in the same cycle when BURST_START=0.

Optional Feature:
AUDIO_TEST_TONE_EN:
- Defined:
  - The test_tone port exists.
  - When test_tone=1, rdreq is held 0 and the FIFO is not touched.
  - Bursts still run on schedule and always produce exactly BURST_LEN samples per line.
  - Sample values form a square wave that toggles every 48 samples, per channel group: +0x4000 / -0x4000 sign-extended to DATA_W.
  - underrun_cnt does not increment.
  - Switching test_tone takes effect only at the next BURST_START.
- Undefined: no test_tone port; only FIFO data is read.

Test Plan:
Bench parameters: H_TOTAL=16, V_TOTAL=4, BURST_START=2, BURST_LEN=4, CHANNELS=2.
1. FIFO preloaded with 0x100..0x10F -> per line, rdreq high for 4 cycles starting at h=3; out_valid at h=5..8; line 0 yields 0x100..0x103 with out_ch 0,1,0,1; underrun_cnt=0.
2. FIFO holds 3 words -> 3 outputs, rdreq never high with rdempty=1; underrun_cnt=1 after DRAIN; the next line with an empty FIFO makes underrun_cnt=2 with no outputs.
3. Counter check over 2 frames -> frame_start pulses exactly every 64 cycles; frame_start is high in the cycle where h_cnt=0 and v_cnt=0.
4. CHANNELS=2 with 3 samples per line for 2 lines -> out_ch sequence 0,1,0,1,0,1 continuous across lines.
5. reset_n pulsed low at h=4 mid-burst -> outputs 0 immediately (asynchronous); after release, counters restart at 0 and the first burst begins at h=3.
6. With AUDIO_TEST_TONE_EN, test_tone=1 and the FIFO empty -> 4 samples per line, rdreq=0, underrun_cnt=0; 48 samples of +0x4000, then -0x4000.

Source files
------------

// File: rtl/audio_burst_reader_if.sv
// FIFO read side and sample output bundle for audio_burst_reader.
// master = the reader, slave = the FIFO/packetiser environment.
interface audio_burst_reader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              rdempty;
    logic              rdreq;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [2:0]        out_ch;
    logic              frame_start;
    logic [15:0]       underrun_cnt;

    modport master (
        input  data, rdempty,
        output rdreq, out_data, out_valid, out_ch, frame_start, underrun_cnt
    );

    modport slave (
        output data, rdempty,
        input  rdreq, out_data, out_valid, out_ch, frame_start, underrun_cnt
    );
endinterface

// File: rtl/audio_burst_reader.sv
// Per-line bounded burst reader from the audio sample FIFO, with channel tagging and underrun count.
// Optional macro AUDIO_TEST_TONE_EN adds a test_tone input that replaces FIFO data with a square wave.
module audio_burst_reader #(
    parameter int DATA_W      = 32,
    parameter int H_TOTAL     = 858,
    parameter int V_TOTAL     = 525,
    parameter int BURST_START = 0,
    parameter int BURST_LEN   = 4,
    parameter int CHANNELS    = 2
) (
    input  logic rclock,
    input  logic reset_n,
    audio_burst_reader_if.master bus
`ifdef AUDIO_TEST_TONE_EN
    ,
    input  logic test_tone
`endif
);

    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_OPEN   = HW'(BURST_START);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [3:0]    LEN      = 4'(BURST_LEN);
    localparam logic [3:0]    LEN_LAST = 4'(BURST_LEN - 1);
    localparam logic [2:0]    CH_LAST  = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_next;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [3:0]        issued, issued_next;
    logic              short_flag, short_next;
    logic              take;
    logic              rdreq_c;
    logic              take_d1;
    logic [2:0]        ch_cnt;
    logic              tone_active;
    logic [DATA_W-1:0] sample_word;

    always_ff @(posedge rclock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Registered so the pulse coincides with h_cnt=0, v_cnt=0.
            bus.frame_start <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
        end
    end

    always_ff @(posedge rclock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            issued           <= '0;
            short_flag       <= 1'b0;
            bus.underrun_cnt <= '0;
        end else begin
            state      <= state_next;
            issued     <= issued_next;
            short_flag <= short_next;
            if (state == DRAIN && short_flag && bus.underrun_cnt != 16'hFFFF)
                bus.underrun_cnt <= bus.underrun_cnt + 16'd1;
        end
    end

    // In tone mode every READ cycle produces a sample without touching the FIFO.
    always_comb begin
        state_next  = state;
        issued_next = issued;
        short_next  = short_flag;
        take        = 1'b0;
        rdreq_c     = 1'b0;
        case (state)
            IDLE: begin
                if (h_cnt == H_OPEN) begin
                    state_next  = READ;
                    issued_next = '0;
                    short_next  = 1'b0;
                end
            end
            READ: begin
                if (issued < LEN) begin
                    if (tone_active) begin
                        take = 1'b1;
                    end else if (!bus.rdempty) begin
                        rdreq_c = 1'b1;
                        take    = 1'b1;
                    end
                end
                if (take) begin
                    issued_next = issued + 4'd1;
                    if (issued == LEN_LAST)
                        state_next = DRAIN;
                end else begin
                    state_next = DRAIN;
                    short_next = (issued < LEN);
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rdreq = rdreq_c;

    // The FIFO word appears one cycle after rdreq, so capture on the delayed take.
    always_ff @(posedge rclock or negedge reset_n) begin
        if (!reset_n) begin
            take_d1       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ch_cnt        <= '0;
        end else begin
            take_d1       <= take;
            bus.out_valid <= take_d1;
            if (take_d1) begin
                bus.out_data <= sample_word;
                bus.out_ch   <= ch_cnt;
                ch_cnt       <= (ch_cnt == CH_LAST) ? 3'd0 : ch_cnt + 3'd1;
            end
        end
    end

`ifdef AUDIO_TEST_TONE_EN
    localparam logic [DATA_W-1:0] TONE_POS = DATA_W'(16384);
    localparam logic [DATA_W-1:0] TONE_NEG = -TONE_POS;

    logic       tone_d1;
    logic [5:0] tone_cnt;
    logic       tone_neg;

    // Mode is sampled at the window opening so a mid-line switch waits for the next line.
    always_ff @(posedge rclock or negedge reset_n) begin
        if (!reset_n) begin
            tone_active <= 1'b0;
            tone_d1     <= 1'b0;
            tone_cnt    <= '0;
            tone_neg    <= 1'b0;
        end else begin
            if (state == IDLE && h_cnt == H_OPEN)
                tone_active <= test_tone;
            tone_d1 <= take && tone_active;
            if (take_d1 && tone_d1) begin
                if (tone_cnt == 6'd47) begin
                    tone_cnt <= '0;
                    tone_neg <= !tone_neg;
                end else begin
                    tone_cnt <= tone_cnt + 6'd1;
                end
            end
        end
    end

    assign sample_word = tone_d1 ? (tone_neg ? TONE_NEG : TONE_POS) : bus.data;
`else
    assign tone_active = 1'b0;
    assign sample_word = bus.data;
`endif

endmodule
